// File: rtl/cjb_param_hw_stack_v_if.sv
// Bundles the stack's command inputs and status outputs between a driver and the stack.
// The master drives push/pop/clr_err/din; the slave (the stack) returns top-of-stack and status.
interface cjb_param_hw_stack_v_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf_err;
    logic             unf_err;

    modport master (
        output push, pop, clr_err, din,
        input  dout, count, empty, full, ovf_err, unf_err
    );

    modport slave (
        input  push, pop, clr_err, din,
        output dout, count, empty, full, ovf_err, unf_err
    );
endinterface

// File: rtl/cjb_param_hw_stack_v.sv
// Parametrised LIFO stack with full/empty/count status and sticky overflow/underflow flags.
// Latency: a push is visible on dout the cycle after its edge; dout is a combinational read.
// Backpressure: none; push on full is dropped (CIRC=0) or evicts the oldest entry (CIRC=1).
module cjb_param_hw_stack_v #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter bit CIRC  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cjb_param_hw_stack_v_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = CW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    base;
    logic [CW-1:0]    cnt;
    logic             ovf;
    logic             unf;

    logic [SW-1:0]    wr_sum;
    logic [SW-1:0]    top_sum;
    logic [PW-1:0]    wr_idx;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    base_inc;
    logic             is_empty;
    logic             is_full;
    logic             do_push;
    logic             do_repl;
    logic             do_pop;

    // Sum of a pointer and an offset is always below 2*DEPTH, so one conditional subtract wraps it.
    function automatic logic [PW-1:0] wrap(input logic [SW-1:0] v);
        if (v >= SW'(DEPTH))
            return PW'(v - SW'(DEPTH));
        return PW'(v);
    endfunction

    always_comb begin
        is_empty = (cnt == '0);
        is_full  = (cnt == CW'(DEPTH));
        wr_sum   = SW'(base) + SW'(cnt);
        top_sum  = wr_sum - SW'(1);
        wr_idx   = wrap(wr_sum);
        top_idx  = wrap(top_sum);
        base_inc = (base == PW'(DEPTH - 1)) ? '0 : base + 1'b1;
        // Push+pop on an empty stack degenerates to a plain push.
        do_push  = bus.push && (!bus.pop || is_empty);
        do_repl  = bus.push && bus.pop && !is_empty;
        do_pop   = bus.pop && !bus.push;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            base <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            // Clear first so that an error raised on the same edge takes precedence.
            if (bus.clr_err) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (do_push) begin
                if (!is_full) begin
                    mem[wr_idx] <= bus.din;
                    cnt         <= cnt + 1'b1;
                end else begin
                    ovf <= 1'b1;
                    if (CIRC) begin
                        // Overwrite the oldest slot and advance the base; it becomes the new top.
                        mem[base] <= bus.din;
                        base      <= base_inc;
                    end
                end
            end else if (do_repl) begin
                mem[top_idx] <= bus.din;
            end else if (do_pop) begin
                if (is_empty)
                    unf <= 1'b1;
                else
                    cnt <= cnt - 1'b1;
            end
        end
    end

    assign bus.dout    = is_empty ? '0 : mem[top_idx];
    assign bus.count   = cnt;
    assign bus.empty   = is_empty;
    assign bus.full    = is_full;
    assign bus.ovf_err = ovf;
    assign bus.unf_err = unf;
endmodule

// File: tb/tb_cjb_param_hw_stack_v.sv
// Drives three stack configurations (8x4 drop, 8x4 circular, 16x5 circular) in lockstep
// against an array-based LIFO reference model.
module tb_cjb_param_hw_stack_v;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] din = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cjb_param_hw_stack_v_if #(.WIDTH(8),  .DEPTH(4)) if0 ();
    cjb_param_hw_stack_v_if #(.WIDTH(8),  .DEPTH(4)) if1 ();
    cjb_param_hw_stack_v_if #(.WIDTH(16), .DEPTH(5)) if2 ();

    assign if0.push = push; assign if0.pop = pop; assign if0.clr_err = clr; assign if0.din = din[7:0];
    assign if1.push = push; assign if1.pop = pop; assign if1.clr_err = clr; assign if1.din = din[7:0];
    assign if2.push = push; assign if2.pop = pop; assign if2.clr_err = clr; assign if2.din = din;

    cjb_param_hw_stack_v #(.WIDTH(8),  .DEPTH(4), .CIRC(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    cjb_param_hw_stack_v #(.WIDTH(8),  .DEPTH(4), .CIRC(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    cjb_param_hw_stack_v #(.WIDTH(16), .DEPTH(5), .CIRC(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    // Reference model: stk[k][0] is the oldest entry, stk[k][n[k]-1] the top.
    logic [15:0] stk [3][8];
    int          n [3];
    bit          movf [3];
    bit          munf [3];
    int          mdep [3]  = '{4, 4, 5};
    bit          mcirc [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] mmask [3] = '{16'h00FF, 16'h00FF, 16'hFFFF};

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            n[k] = 0; movf[k] = 1'b0; munf[k] = 1'b0;
        end
    endtask

    task automatic model_step(int k, bit p, bit q, bit c, logic [15:0] d);
        d = d & mmask[k];
        if (c) begin
            movf[k] = 1'b0; munf[k] = 1'b0;
        end
        if (p && (!q || n[k] == 0)) begin
            if (n[k] < mdep[k]) begin
                stk[k][n[k]] = d;
                n[k]++;
            end else begin
                movf[k] = 1'b1;
                if (mcirc[k]) begin
                    for (int i = 0; i < mdep[k] - 1; i++) stk[k][i] = stk[k][i+1];
                    stk[k][mdep[k]-1] = d;
                end
            end
        end else if (p && q) begin
            stk[k][n[k]-1] = d;
        end else if (q) begin
            if (n[k] == 0) munf[k] = 1'b1;
            else n[k]--;
        end
    endtask

    function automatic logic [23:0] exp_status(int k);
        logic [15:0] t;
        t = (n[k] == 0) ? 16'h0000 : stk[k][n[k]-1];
        return {t, 4'(n[k]), n[k] == 0, n[k] == mdep[k], movf[k], munf[k]};
    endfunction

    function automatic logic [23:0] obs_status(int k);
        case (k)
            0:       return {8'h00, if0.dout, 1'b0, if0.count, if0.empty, if0.full, if0.ovf_err, if0.unf_err};
            1:       return {8'h00, if1.dout, 1'b0, if1.count, if1.empty, if1.full, if1.ovf_err, if1.unf_err};
            default: return {if2.dout, 1'b0, if2.count, if2.empty, if2.full, if2.ovf_err, if2.unf_err};
        endcase
    endfunction

    task automatic cycle(bit p, bit q, bit c, logic [15:0] d);
        @(negedge clk);
        push = p; pop = q; clr = c; din = d;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, p, q, c, d);
        #1;
        push = 1'b0; pop = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (obs_status(k) !== exp_status(k)) begin
                fails++; $display("FAIL reset u%0d: got %h want %h", k, obs_status(k), exp_status(k));
            end
        end
        tests++;
        if ({if0.empty, if0.full, if0.dout} !== {1'b1, 1'b0, 8'h00}) begin
            fails++; $display("FAIL reset_flags u0: got %b%b %h want 10 00", if0.empty, if0.full, if0.dout);
        end
    endtask

    // Fill with A1..A4, drain, refill and push once more past full.
    task automatic test_fill_drain();
        logic [7:0] exp0 [4] = '{8'hA4, 8'hA3, 8'hA2, 8'hA1};
        logic [7:0] exp1 [4] = '{8'h55, 8'hA4, 8'hA3, 8'hA2};
        logic [7:0] after [4] = '{8'hA3, 8'hA2, 8'hA1, 8'h00};
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 16'h00A1 + 16'(i));
        tests++;
        if ({if0.count, if0.full, if0.dout} !== {3'd4, 1'b1, 8'hA4}) begin
            fails++; $display("FAIL fill u0: got cnt=%0d full=%b dout=%h want 4 1 a4", if0.count, if0.full, if0.dout);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 16'h0000);
            tests++;
            if (if0.dout !== after[i]) begin
                fails++; $display("FAIL drain u0 step %0d: got %h want %h", i, if0.dout, after[i]);
            end
        end
        tests++;
        if (if0.empty !== 1'b1) begin
            fails++; $display("FAIL drain_empty u0: got %b want 1", if0.empty);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 16'h00A1 + 16'(i));
        cycle(1'b1, 1'b0, 1'b0, 16'h0055);
        tests++;
        if ({if0.count, if0.dout, if0.ovf_err} !== {3'd4, 8'hA4, 1'b1}) begin
            fails++; $display("FAIL ovf_drop u0: got cnt=%0d dout=%h ovf=%b want 4 a4 1", if0.count, if0.dout, if0.ovf_err);
        end
        tests++;
        if ({if1.count, if1.dout, if1.ovf_err} !== {3'd4, 8'h55, 1'b1}) begin
            fails++; $display("FAIL ovf_circ u1: got cnt=%0d dout=%h ovf=%b want 4 55 1", if1.count, if1.dout, if1.ovf_err);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({if0.dout, if1.dout} !== {exp0[i], exp1[i]}) begin
                fails++; $display("FAIL pop_order step %0d: got %h/%h want %h/%h", i, if0.dout, if1.dout, exp0[i], exp1[i]);
            end
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (obs_status(k) !== exp_status(k)) begin
                    fails++; $display("FAIL pop_model u%0d: got %h want %h", k, obs_status(k), exp_status(k));
                end
            end
            cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        end
        tests++;
        if ({if0.empty, if1.empty} !== 2'b11) begin
            fails++; $display("FAIL pop_empty: got %b%b want 11", if0.empty, if1.empty);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        tests++;
        if ({if0.unf_err, if0.count} !== {1'b1, 3'd0}) begin
            fails++; $display("FAIL unf_set: got unf=%b cnt=%0d want 1 0", if0.unf_err, if0.count);
        end
        cycle(1'b0, 1'b1, 1'b1, 16'h0000);
        tests++;
        if (if0.unf_err !== 1'b1) begin
            fails++; $display("FAIL unf_set_wins: got %b want 1", if0.unf_err);
        end
        cycle(1'b0, 1'b0, 1'b1, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (obs_status(k) !== exp_status(k)) begin
                fails++; $display("FAIL unf_clear u%0d: got %h want %h", k, obs_status(k), exp_status(k));
            end
        end
    endtask

    task automatic test_replace();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 16'h0010);
        cycle(1'b1, 1'b1, 1'b0, 16'h0020);
        tests++;
        if ({if0.count, if0.dout} !== {3'd1, 8'h20}) begin
            fails++; $display("FAIL replace: got cnt=%0d dout=%h want 1 20", if0.count, if0.dout);
        end
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(1'b1, 1'b1, 1'b0, 16'h0030);
        tests++;
        if ({if0.count, if0.dout, if0.unf_err} !== {3'd1, 8'h30, 1'b0}) begin
            fails++; $display("FAIL replace_empty: got cnt=%0d dout=%h unf=%b want 1 30 0", if0.count, if0.dout, if0.unf_err);
        end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (obs_status(k) !== exp_status(k)) begin
                fails++; $display("FAIL replace_model u%0d: got %h want %h", k, obs_status(k), exp_status(k));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'hBEE0 + 16'(i));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (obs_status(k) !== exp_status(k)) begin
                fails++; $display("FAIL reset_mid u%0d: got %h want %h", k, obs_status(k), exp_status(k));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 16'h0077);
        tests++;
        if ({if0.count, if0.dout, if2.count, if2.dout} !== {3'd1, 8'h77, 3'd1, 16'h0077}) begin
            fails++; $display("FAIL reset_push: got %0d %h %0d %h want 1 77 1 0077", if0.count, if0.dout, if2.count, if2.dout);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 8, 16'($urandom));
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (obs_status(k) !== exp_status(k)) begin
                    fails++; $display("FAIL random i=%0d u%0d: got %h want %h", i, k, obs_status(k), exp_status(k));
                end
            end
            if ($urandom_range(0, 99) < 2) begin
                rst_n = 1'b0;
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_underflow();
        test_replace();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
